// File: rtl/shift_pkg.sv
// Shared definitions for the serial link: FSM state encoding and counter width helper.
package shift_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_t;

    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: flags the first and last clock cycle of every serial bit period.
module bit_tick_gen
    import shift_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_first,
    output logic o_last
);

    localparam int PCW = clog2_min1(CLKS_PER_BIT);
    localparam logic [PCW-1:0] LAST_CNT = PCW'(CLKS_PER_BIT - 1);

    logic [PCW-1:0] period_cnt_r;

    assign o_first = (period_cnt_r == {PCW{1'b0}});
    assign o_last  = (period_cnt_r == LAST_CNT);

    // Period counter: restarts on clear, wraps after the last cycle of a period.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            period_cnt_r <= {PCW{1'b0}};
        end else if (i_clear || o_last) begin
            period_cnt_r <= {PCW{1'b0}};
        end else begin
            period_cnt_r <= period_cnt_r + PCW'(1);
        end
    end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready intake and back-to-back word support.
module shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter bit FILL_MSB_TO_LSB = 1'b1,
    parameter int CLKS_PER_BIT    = 1
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_out,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BCW = clog2_min1(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] PENULT_BIT = BCW'(WIDTH - 2);

    shift_state_t     state_r;
    shift_state_t     state_next_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] shifted_s;
    logic [BCW-1:0]   bit_cnt_r;
    logic [BCW-1:0]   bit_cnt_next_s;
    logic             out_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_s;
    logic             accept_s;
    logic             word_end_s;
    logic             period_end_s;
    logic             tick_clear_s;
    logic             first_s;
    logic             last_s;
    logic             unused_first_s;

    // Period timer is held at zero while idle and restarted by every accepted word.
    assign tick_clear_s = accept_s || (state_r == IDLE);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .i_clear  (tick_clear_s),
        .o_first  (first_s),
        .o_last   (last_s)
    );

    // Period start is reserved for receiver-side enable logic; the transmitter keys off period end.
    assign unused_first_s = first_s;

    assign period_end_s = (state_r == SHIFT) && last_s;
    assign word_end_s   = period_end_s && (bit_cnt_r == LAST_BIT);
    assign accept_s     = i_valid && ready_s;
    assign shifted_s    = FILL_MSB_TO_LSB ? {1'b0, shift_r[WIDTH-1:1]}
                                          : {shift_r[WIDTH-2:0], 1'b0};

    // Next-state and ready decode; ready opens only in the final cycle of the final bit.
    always_comb begin
        state_next_s = state_r;
        ready_s      = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (i_valid) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                ready_s = word_end_s;
                if (word_end_s && !i_valid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                ready_s      = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath next values: load on accept, otherwise shift and count at each period end.
    always_comb begin
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        if (accept_s) begin
            shift_next_s   = i_data;
            bit_cnt_next_s = {BCW{1'b0}};
        end else if (period_end_s) begin
            shift_next_s = shifted_s;
            if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_next_s = {BCW{1'b0}};
            end else begin
                bit_cnt_next_s = bit_cnt_r + BCW'(1);
            end
        end else begin
            shift_next_s   = shift_r;
            bit_cnt_next_s = bit_cnt_r;
        end
    end

    // State, datapath and output strobes; strobes are computed one cycle ahead of the bit they mark.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= IDLE;
            shift_r     <= {WIDTH{1'b0}};
            bit_cnt_r   <= {BCW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            shift_r     <= shift_next_s;
            bit_cnt_r   <= bit_cnt_next_s;
            out_valid_r <= accept_s || (period_end_s && (bit_cnt_r != LAST_BIT));
            busy_r      <= (state_next_s == SHIFT);
            done_r      <= period_end_s && (bit_cnt_r == PENULT_BIT);
        end
    end

    // The register is all zeros once a word has fully shifted out, so the idle line stays low.
    assign o_out       = FILL_MSB_TO_LSB ? shift_r[0] : shift_r[WIDTH-1];
    assign o_out_valid = out_valid_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_ready     = ready_s;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: LSB-first fast link (dut_a) and MSB-first 4-clock link (dut_b).
module tb_shift_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, a_out, a_ov, a_busy, a_done;
    logic       b_ready, b_out, b_ov, b_busy, b_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic       qa[$];
    logic       qb[$];
    logic [7:0] qwa[$];
    logic [7:0] qwb[$];
    logic [7:0] rxa = 8'h00;
    logic [7:0] rxb = 8'h00;
    int         rxa_cnt = 0;
    int         rxb_cnt = 0;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic [7:0] exp_word;
        logic       exp_bit0;
    } vec_t;

    vec_t tbl[6];

    shift_serializer #(.WIDTH(8), .FILL_MSB_TO_LSB(1'b1), .CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .i_reset_n(rst_n), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_ready), .o_out(a_out), .o_out_valid(a_ov), .o_busy(a_busy), .o_done(a_done)
    );

    shift_serializer #(.WIDTH(8), .FILL_MSB_TO_LSB(1'b0), .CLKS_PER_BIT(4)) dut_b (
        .clk(clk), .i_reset_n(rst_n), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready), .o_out(b_out), .o_out_valid(b_ov), .o_busy(b_busy), .o_done(b_done)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, want %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bit stream of a word: LSB first on dut_a, MSB first on dut_b.
    task automatic exp_push(input int ch, input logic [7:0] d, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            if (ch == 0) qa.push_back(d[k]);
            else         qb.push_back(d[7-k]);
        end
        if (ch == 0) qwa.push_back(w);
        else         qwb.push_back(w);
    endtask

    task automatic mon_a();
        if (!rst_n) begin
            rxa_cnt = 0;
        end else if (a_ov) begin
            chk1("a_bit_queued", qa.size() != 0, 1'b1);
            if (qa.size() != 0) chk1("a_bit", a_out, qa.pop_front());
            rxa = {a_out, rxa[7:1]};
            rxa_cnt++;
            chk1("a_done", a_done, rxa_cnt == 8);
            if (rxa_cnt == 8) begin
                rxa_cnt = 0;
                chk1("a_word_queued", qwa.size() != 0, 1'b1);
                if (qwa.size() != 0) chk8("a_rx_word", rxa, qwa.pop_front());
            end
        end else begin
            chk1("a_done_quiet", a_done, 1'b0);
        end
    endtask

    task automatic mon_b();
        if (!rst_n) begin
            rxb_cnt = 0;
        end else if (b_ov) begin
            chk1("b_bit_queued", qb.size() != 0, 1'b1);
            if (qb.size() != 0) chk1("b_bit", b_out, qb.pop_front());
            rxb = {rxb[6:0], b_out};
            rxb_cnt++;
            chk1("b_done", b_done, rxb_cnt == 8);
            if (rxb_cnt == 8) begin
                rxb_cnt = 0;
                chk1("b_word_queued", qwb.size() != 0, 1'b1);
                if (qwb.size() != 0) chk8("b_rx_word", rxb, qwb.pop_front());
            end
        end else begin
            chk1("b_done_quiet", b_done, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        mon_a();
        mon_b();
    end

    // Drive a word and return at the negedge following its acceptance; valid is left high.
    task automatic send(input int ch, input logic [7:0] d, input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        if (ch == 0) begin a_data = d; a_valid = 1'b1; end
        else         begin b_data = d; b_valid = 1'b1; end
        exp_push(ch, d, w);
        for (int t = 0; t < 100 && !ok; t++) begin
            ok = (ch == 0) ? a_ready : b_ready;
            @(negedge clk);
        end
        chk1("accept_in_time", ok, 1'b1);
    endtask

    task automatic drain(input int ch);
        bit idle_ok;
        idle_ok = 1'b0;
        for (int t = 0; t < 300 && !idle_ok; t++) begin
            if (((ch == 0) ? a_busy : b_busy) == 1'b0) idle_ok = 1'b1;
            else @(negedge clk);
        end
        chk1("drain_in_time", idle_ok, 1'b1);
    endtask

    initial begin
        logic seq_a5[8];
        seq_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[0] = '{0, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{0, 8'hFF, 8'hFF, 1'b1};
        tbl[2] = '{1, 8'h81, 8'h81, 1'b1};
        tbl[3] = '{1, 8'h5A, 8'h5A, 1'b0};
        tbl[4] = '{0, 8'h69, 8'h69, 1'b1};
        tbl[5] = '{1, 8'h36, 8'h36, 1'b0};

        rst_n = 1'b0;
        a_data = 8'h00; b_data = 8'h00; a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_a_out", a_out, 1'b0);   chk1("rst_a_ov", a_ov, 1'b0);
        chk1("rst_a_busy", a_busy, 1'b0); chk1("rst_a_done", a_done, 1'b0);
        chk1("rst_a_ready", a_ready, 1'b1);
        chk1("rst_b_out", b_out, 1'b0);   chk1("rst_b_ready", b_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // LSB-first 0xA5 with explicit per-cycle expectations
        send(0, 8'hA5, 8'hA5);
        a_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk1("a5_out", a_out, seq_a5[k]);
            chk1("a5_ov", a_ov, 1'b1);
            chk1("a5_busy", a_busy, 1'b1);
            chk1("a5_done", a_done, k == 7);
            chk1("a5_ready", a_ready, k == 7);
            @(negedge clk);
        end
        chk1("a5_end_busy", a_busy, 1'b0);
        chk1("a5_end_out", a_out, 1'b0);
        chk1("a5_end_ov", a_ov, 1'b0);
        chk1("a5_end_ready", a_ready, 1'b1);
        @(negedge clk);

        // Table-driven words on both links
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].ch, tbl[i].data, tbl[i].exp_word);
            if (tbl[i].ch == 0) begin
                a_valid = 1'b0;
                chk1("tbl_bit0_a", a_out, tbl[i].exp_bit0);
            end else begin
                b_valid = 1'b0;
                chk1("tbl_bit0_b", b_out, tbl[i].exp_bit0);
            end
            drain(tbl[i].ch);
            @(negedge clk);
        end

        // Back-to-back with a stalled, changing i_data while the first word shifts
        send(0, 8'h3C, 8'h3C);
        a_data = 8'hFF;
        exp_push(0, 8'hC3, 8'hC3);
        for (int k = 0; k < 16; k++) begin
            if (k == 4) a_data = 8'hC3;
            if (k == 8) a_valid = 1'b0;
            chk1("b2b_ov", a_ov, 1'b1);
            chk1("b2b_busy", a_busy, 1'b1);
            chk1("b2b_ready", a_ready, (k == 7) || (k == 15));
            @(negedge clk);
        end
        chk1("b2b_end_busy", a_busy, 1'b0);
        chk1("b2b_end_ov", a_ov, 1'b0);
        @(negedge clk);

        // Slow bit rate: 0x01 MSB first, four clocks per bit
        send(1, 8'h01, 8'h01);
        b_valid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            chk1("slow_out", b_out, c >= 28);
            chk1("slow_ov", b_ov, (c % 4) == 0);
            chk1("slow_ready", b_ready, c == 31);
            chk1("slow_busy", b_busy, 1'b1);
            chk1("slow_done", b_done, c == 28);
            @(negedge clk);
        end
        chk1("slow_end_busy", b_busy, 1'b0);
        chk1("slow_end_ready", b_ready, 1'b1);
        @(negedge clk);

        // Asynchronous reset in the middle of bit 3
        send(0, 8'h0F, 8'h0F);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk1("mid_pre_out", a_out, 1'b1);
        chk1("mid_pre_busy", a_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_out", a_out, 1'b0);
        chk1("mid_rst_ov", a_ov, 1'b0);
        chk1("mid_rst_busy", a_busy, 1'b0);
        chk1("mid_rst_done", a_done, 1'b0);
        chk1("mid_rst_ready", a_ready, 1'b1);
        qa.delete();
        qwa.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 8'h5A, 8'h5A);
        a_valid = 1'b0;
        drain(0);
        drain(1);
        repeat (2) @(negedge clk);

        chk1("a_bits_consumed", qa.size() == 0, 1'b1);
        chk1("a_words_consumed", qwa.size() == 0, 1'b1);
        chk1("b_bits_consumed", qb.size() == 0, 1'b1);
        chk1("b_words_consumed", qwb.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
